// File: rtl/regfile_write_arbiter.sv
// Round-robin two-requester write arbiter with a one-entry output stage; latency 1, stage holds while wr_busy.
// Define REGFILE_FWD_EN to drive pending stage data onto fwd_data_k for hazarded queries.
module regfile_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              wr_busy,
    output logic              reg_write,
    output logic [ADDR_W-1:0] write_address,
    output logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] query_addr_1,
    input  logic [ADDR_W-1:0] query_addr_2,
    output logic              hazard_1,
    output logic              hazard_2,
    output logic [DATA_W-1:0] fwd_data_1,
    output logic [DATA_W-1:0] fwd_data_2,
    output logic [15:0]       commit_count
);

    logic              os_valid_q, os_valid_d;
    logic [ADDR_W-1:0] os_addr_q, os_addr_d;
    logic [DATA_W-1:0] os_data_q, os_data_d;
    logic              last_grant_q, last_grant_d;
    logic [15:0]       commit_count_q, commit_count_d;

    logic              commit;
    logic              can_accept;
    logic              grant0, grant1;
    logic              accept;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;

    // Outputs are gated by rst so nothing leaks out during a reset cycle.
    assign commit     = rst & os_valid_q & ~wr_busy;
    assign can_accept = rst & (~os_valid_q | commit);
    assign grant0     = req0_valid & (~req1_valid | last_grant_q);
    assign grant1     = req1_valid & (~req0_valid | ~last_grant_q);
    assign req0_ready = can_accept & grant0;
    assign req1_ready = can_accept & grant1;
    assign accept     = req0_ready | req1_ready;
    assign win_addr   = req1_ready ? req1_addr : req0_addr;
    assign win_data   = req1_ready ? req1_data : req0_data;

    always_comb begin
        os_valid_d     = os_valid_q;
        os_addr_d      = os_addr_q;
        os_data_d      = os_data_q;
        last_grant_d   = last_grant_q;
        commit_count_d = commit_count_q + {15'd0, commit};
        if (commit) begin
            os_valid_d = 1'b0;
        end
        if (accept) begin
            last_grant_d = req1_ready;
            // Writes to register 0 are swallowed: they win arbitration but never reach the stage.
            if (win_addr != '0) begin
                os_valid_d = 1'b1;
                os_addr_d  = win_addr;
                os_data_d  = win_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            os_valid_q     <= 1'b0;
            os_addr_q      <= '0;
            os_data_q      <= '0;
            last_grant_q   <= 1'b1;
            commit_count_q <= 16'd0;
        end else begin
            os_valid_q     <= os_valid_d;
            os_addr_q      <= os_addr_d;
            os_data_q      <= os_data_d;
            last_grant_q   <= last_grant_d;
            commit_count_q <= commit_count_d;
        end
    end

    assign reg_write     = commit;
    assign write_address = os_addr_q;
    assign write_data    = os_data_q;
    assign commit_count  = commit_count_q;

    assign hazard_1 = rst & os_valid_q & (query_addr_1 == os_addr_q) & (query_addr_1 != '0);
    assign hazard_2 = rst & os_valid_q & (query_addr_2 == os_addr_q) & (query_addr_2 != '0);

`ifdef REGFILE_FWD_EN
    assign fwd_data_1 = hazard_1 ? os_data_q : '0;
    assign fwd_data_2 = hazard_2 ? os_data_q : '0;
`else
    assign fwd_data_1 = '0;
    assign fwd_data_2 = '0;
`endif

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the width of the write data and forwarded data.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning the width of the register address; 2**ADDR_W registers.
REQ-003 The block SHALL use one clock; reset is synchronous and active-low.
REQ-004 Port clk, input, 1, meaning the sole clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1, meaning the synchronous active-low reset.
REQ-006 Port req0_valid / req1_valid, input, 1 each, meaning requester 0/1 offers a write.
REQ-007 Port req0_addr / req1_addr, input, ADDR_W each, meaning the destination register.
REQ-008 Port req0_data / req1_data, input, DATA_W each, meaning the write data.
REQ-009 Port req0_ready / req1_ready, output, 1 each, meaning the offer is accepted this cycle.
REQ-010 Port wr_busy, input, 1, meaning the register-file write port is unavailable this cycle.
REQ-011 Port reg_write, output, 1, meaning the write strobe to the register file.
REQ-012 Port write_address, output, ADDR_W, meaning the destination address to the register file.
REQ-013 Port write_data, output, DATA_W, meaning the data to the register file.
REQ-014 Port query_addr_1 / query_addr_2, input, ADDR_W each, meaning the register-file read addresses to check.
REQ-015 Port hazard_1 / hazard_2, output, 1 each, meaning the queried register has an uncommitted write.
REQ-016 Port fwd_data_1 / fwd_data_2, output, DATA_W each, meaning the pending data for a hazarded query.
REQ-017 Port commit_count, output, 16, meaning the number of writes committed, wrapping modulo 2**16.

Function
REQ-018 The block SHALL hold a one-entry output stage (os_valid, os_addr, os_data).
REQ-019 reg_write SHALL equal os_valid AND NOT wr_busy; write_address/write_data SHALL equal os_addr/os_data; an entry commits in any cycle where reg_write=1.
REQ-020 The stage SHALL accept a new entry when os_valid=0 or a commit occurs in the same cycle (simultaneous commit and load allowed, no bubble).
REQ-021 Arbitration SHALL be round-robin: register last_grant; with both valid, the requester not equal to last_grant wins; with one valid, it wins.
REQ-022 reqN_ready SHALL be 1 only for the winner and only when the stage can accept; readyN is combinational from the current inputs and state.
REQ-023 On acceptance the stage SHALL load the winner's addr/data at the edge, and last_grant SHALL update to the winner.
REQ-024 An accepted request with addr=0 SHALL be discarded (stage not loaded, no commit) but SHALL still update last_grant.
REQ-025 Latency SHALL be 1: acceptance at edge N gives reg_write=1 in cycle N+1 if wr_busy=0; the entry holds unchanged while wr_busy=1.
REQ-026 hazard_k SHALL be os_valid AND query_addr_k==os_addr AND query_addr_k!=0.
REQ-027 commit_count SHALL increment by 1 per commit and wrap from 16'hFFFF to 0.
REQ-028 Requesters SHALL hold valid/addr/data stable until ready; the block SHALL NOT depend on this for correctness of other requesters.

Reset
REQ-029 With rst=0 at an edge: os_valid=0, last_grant=1, commit_count=0; reg_write, readyN, hazard_k and fwd_data_k SHALL read 0 during reset.
REQ-030 Reset mid-operation SHALL drop any pending entry without issuing its write; no request is accepted in a reset cycle.

Configuration
REQ-031 Macro REGFILE_FWD_EN: when defined, fwd_data_k SHALL equal os_data when hazard_k=1, else 0.
REQ-032 When REGFILE_FWD_EN is undefined, fwd_data_k SHALL be constant 0; hazard_k is unaffected.

Verification
REQ-033 After reset, req0 and req1 both valid continuously, wr_busy=0 -> grants alternate req0, req1, req0...; one commit per cycle; commit_count=4 after 4 commits.
REQ-034 req1 writes addr 7, data 0xDEADBEEF, with wr_busy=1 for 3 cycles -> reg_write stays 0, entry held, hazard_1=1 for query_addr_1=7 and fwd_data_1=0xDEADBEEF (FWD_EN); it commits in the first cycle wr_busy=0.
REQ-035 req0 writes addr 0 -> req0_ready=1, reg_write never asserts, commit_count unchanged, next tie granted to req1.
REQ-036 Stage full with wr_busy=1 and req0 valid -> req0_ready=0; wr_busy drops -> commit and new load at the same edge, no idle cycle.
REQ-037 rst=0 asserted while an entry to addr 3 is pending -> no write to 3; after release, os_valid=0, commit_count=0, first tie granted to req0.
REQ-038 commit_count preloaded to 16'hFFFF via 65535 commits -> the next commit gives 0.
